// File: rtl/kernel_mem_seq.sv
// kernel_mem_seq: kernel/bias store for the convolution columns.
// Write side is a ring buffer bounded by a host-set end address; read side
// walks a queue of region descriptors, loading the bias once and streaming
// the kernel words `repeat` times before moving to the next region.
module kernel_mem_seq #(
  parameter int GROUP_NB   = 4,
  parameter int KER_WIDTH  = 16,
  parameter int DEPTH_NB   = 16,
  parameter int MEM_AWIDTH = 10,
  parameter int MEM_DEPTH  = 1 << MEM_AWIDTH,
  parameter int RPT_WIDTH  = 8,
  parameter int CFG_AWIDTH = 1,
  localparam int DW        = GROUP_NB * KER_WIDTH * DEPTH_NB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_AWIDTH-1:0] wr_cfg_end,
  input  logic                  wr_cfg_set,
  input  logic [DW-1:0]         wr_data,
  input  logic                  wr_data_val,
  output logic                  wr_data_rdy,
  input  logic [MEM_AWIDTH-1:0] rd_cfg_start,
  input  logic [MEM_AWIDTH-1:0] rd_cfg_end,
  input  logic [RPT_WIDTH-1:0]  rd_cfg_rpt,
  input  logic                  rd_cfg_val,
  output logic                  rd_cfg_rdy,
  output logic [DW-1:0]         rd_bias,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_data_val,
  output logic                  rd_data_last,
  input  logic                  rd_data_rdy,
  output logic                  rd_region_done
);

  localparam logic [MEM_AWIDTH-1:0] LAST_ADDR = MEM_AWIDTH'(MEM_DEPTH - 1);
  localparam int                    CFG_DEPTH = 1 << CFG_AWIDTH;
  localparam int                    DESC_W    = 2 * MEM_AWIDTH + RPT_WIDTH;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BIAS   = 2'd1;
  localparam logic [1:0] ST_FILL   = 2'd2;
  localparam logic [1:0] ST_STREAM = 2'd3;

  // Kernel/bias storage: written by the ring-buffer side, read with a registered port.
  logic [DW-1:0] mem_q [MEM_DEPTH];

  // ---------------------------------------------------------------- write side
  logic [MEM_AWIDTH-1:0] wr_ptr_q;
  logic [MEM_AWIDTH-1:0] wr_end_q;
  logic                  wr_ptr_wrap_q;
  logic                  wr_end_wrap_q;
  logic                  wr_fire;

  // Full when the pointer has caught up with the end address one lap behind.
  assign wr_data_rdy = ~((wr_ptr_wrap_q != wr_end_wrap_q) && (wr_ptr_q == wr_end_q));
  assign wr_fire     = wr_data_val & wr_data_rdy;

  // Write pointer and end-address bookkeeping; an end at or below the old one starts a new lap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      wr_ptr_wrap_q <= 1'b0;
      wr_end_q      <= '0;
      wr_end_wrap_q <= 1'b1;
    end else begin
      if (wr_fire) begin
        if (wr_ptr_q == LAST_ADDR) begin
          wr_ptr_q      <= '0;
          wr_ptr_wrap_q <= ~wr_ptr_wrap_q;
        end else begin
          wr_ptr_q <= wr_ptr_q + MEM_AWIDTH'(1);
        end
      end
      if (wr_cfg_set) begin
        wr_end_q <= wr_cfg_end;
        if (wr_end_q >= wr_cfg_end) begin
          wr_end_wrap_q <= ~wr_end_wrap_q;
        end
      end
    end
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------- descriptor queue
  logic [DESC_W-1:0]     cfg_mem_q [CFG_DEPTH];
  logic [CFG_AWIDTH-1:0] cfg_wp_q;
  logic [CFG_AWIDTH-1:0] cfg_rp_q;
  logic [CFG_AWIDTH:0]   cfg_cnt_q;
  logic                  cfg_full;
  logic                  cfg_empty;
  logic                  cfg_push;
  logic                  cfg_pop;
  logic [DESC_W-1:0]     desc;
  logic [MEM_AWIDTH-1:0] desc_start;
  logic [MEM_AWIDTH-1:0] desc_end;
  logic [RPT_WIDTH-1:0]  desc_rpt;
  logic [RPT_WIDTH-1:0]  desc_rpt_eff;

  assign cfg_full   = (cfg_cnt_q == (CFG_AWIDTH + 1)'(CFG_DEPTH));
  assign cfg_empty  = (cfg_cnt_q == '0);
  assign rd_cfg_rdy = ~cfg_full;
  // A zero-length region (start == end) would never reach its end marker, so it is dropped.
  assign cfg_push   = rd_cfg_val & ~cfg_full & (rd_cfg_start != rd_cfg_end);

  assign desc         = cfg_mem_q[cfg_rp_q];
  assign desc_start   = desc[DESC_W-1 -: MEM_AWIDTH];
  assign desc_end     = desc[RPT_WIDTH +: MEM_AWIDTH];
  assign desc_rpt     = desc[RPT_WIDTH-1:0];
  assign desc_rpt_eff = (desc_rpt == '0) ? RPT_WIDTH'(1) : desc_rpt;

  // Descriptor storage; entries are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (cfg_push) begin
      cfg_mem_q[cfg_wp_q] <= {rd_cfg_start, rd_cfg_end, rd_cfg_rpt};
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_wp_q  <= '0;
      cfg_rp_q  <= '0;
      cfg_cnt_q <= '0;
    end else begin
      if (cfg_push) cfg_wp_q <= cfg_wp_q + CFG_AWIDTH'(1);
      if (cfg_pop)  cfg_rp_q <= cfg_rp_q + CFG_AWIDTH'(1);
      if (cfg_push && !cfg_pop)      cfg_cnt_q <= cfg_cnt_q + (CFG_AWIDTH + 1)'(1);
      else if (!cfg_push && cfg_pop) cfg_cnt_q <= cfg_cnt_q - (CFG_AWIDTH + 1)'(1);
    end
  end

  // ------------------------------------------------------------------ read FSM
  logic [1:0]            state_q, state_d;
  logic [MEM_AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [MEM_AWIDTH-1:0] start_q, start_d;
  logic [MEM_AWIDTH-1:0] end_q, end_d;
  logic [RPT_WIDTH-1:0]  rpt_q, rpt_d;
  logic [RPT_WIDTH-1:0]  pass_q, pass_d;
  logic                  val_q, val_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic [DW-1:0]         bias_q;
  logic [DW-1:0]         data_q;
  logic                  bias_ld;
  logic                  data_ld;

  logic [MEM_AWIDTH-1:0] start_p1;
  logic [MEM_AWIDTH-1:0] ptr_adv;
  logic [RPT_WIDTH-1:0]  pass_adv;
  logic                  at_end;
  logic                  is_last;

  // End-of-pass restarts at the first kernel word; this wins over the memory wrap.
  assign start_p1 = (start_q == LAST_ADDR) ? '0 : start_q + MEM_AWIDTH'(1);
  assign at_end   = (rd_ptr_q == end_q);
  assign ptr_adv  = at_end ? start_p1 :
                    ((rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + MEM_AWIDTH'(1));
  assign pass_adv = at_end ? pass_q + RPT_WIDTH'(1) : pass_q;
  assign is_last  = at_end && (pass_q == rpt_q - RPT_WIDTH'(1));

  // Next-state logic: pop a region, load bias, then fetch one word per accepted beat.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    start_d  = start_q;
    end_d    = end_q;
    rpt_d    = rpt_q;
    pass_d   = pass_q;
    val_d    = val_q;
    last_d   = last_q;
    done_d   = 1'b0;
    bias_ld  = 1'b0;
    data_ld  = 1'b0;
    cfg_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cfg_empty) begin
          cfg_pop  = 1'b1;
          start_d  = desc_start;
          end_d    = desc_end;
          rpt_d    = desc_rpt_eff;
          rd_ptr_d = desc_start;
          pass_d   = '0;
          state_d  = ST_BIAS;
        end
      end
      ST_BIAS: begin
        bias_ld  = 1'b1;
        rd_ptr_d = start_p1;
        state_d  = ST_FILL;
      end
      ST_FILL: begin
        data_ld  = 1'b1;
        val_d    = 1'b1;
        last_d   = is_last;
        rd_ptr_d = ptr_adv;
        pass_d   = pass_adv;
        state_d  = ST_STREAM;
      end
      ST_STREAM: begin
        if (val_q && rd_data_rdy) begin
          if (last_q) begin
            val_d   = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            data_ld  = 1'b1;
            val_d    = 1'b1;
            last_d   = is_last;
            rd_ptr_d = ptr_adv;
            pass_d   = pass_adv;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      start_q  <= '0;
      end_q    <= '0;
      rpt_q    <= RPT_WIDTH'(1);
      pass_q   <= '0;
      val_q    <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      start_q  <= start_d;
      end_q    <= end_d;
      rpt_q    <= rpt_d;
      pass_q   <= pass_d;
      val_q    <= val_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  // Registered memory reads into the bias and data output registers (old data on collision).
  always_ff @(posedge clk) begin
    if (rst) begin
      bias_q <= '0;
      data_q <= '0;
    end else begin
      if (bias_ld) bias_q <= mem_q[rd_ptr_q];
      if (data_ld) data_q <= mem_q[rd_ptr_q];
    end
  end

  assign rd_bias        = bias_q;
  assign rd_data        = data_q;
  assign rd_data_val    = val_q;
  assign rd_data_last   = last_q;
  assign rd_region_done = done_q;

endmodule

// File: doc/kernel_mem_seq.md
Name: kernel_mem_seq

Overview:
- Next-generation kernel/bias store for the convolution columns.
- Write side: ring buffer bounded by a host-set end address.
- Read side: accepts a queue of read-region descriptors, each with its own repeat count.
- Per region: loads the bias once, streams the kernel words `repeat` times over a valid/ready handshake with a last marker, then retires and starts the next queued region with no host intervention.

Parameters:
GROUP_NB, 4, convolution groups.
KER_WIDTH, 16, bits per kernel value.
DEPTH_NB, 16, kernel values per group per word.
MEM_AWIDTH, 10, memory address width.
MEM_DEPTH, 1<<MEM_AWIDTH, memory words; must be <= 2^MEM_AWIDTH.
RPT_WIDTH, 8, repeat-count width.
CFG_AWIDTH, 1, log2 of the descriptor queue depth (default depth 2).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
wr_cfg_end  in  MEM_AWIDTH  write-region end (exclusive).
wr_cfg_set  in  1  load wr_cfg_end.
wr_data  in  DW  kernel/bias word; DW = GROUP_NB*KER_WIDTH*DEPTH_NB.
wr_data_val  in  1  write valid.
wr_data_rdy  out  1  not full.
rd_cfg_start  in  MEM_AWIDTH  bias address; kernel words start at rd_cfg_start+1.
rd_cfg_end  in  MEM_AWIDTH  last kernel address (inclusive).
rd_cfg_rpt  in  RPT_WIDTH  number of passes; 0 is treated as 1.
rd_cfg_val  in  1  descriptor valid.
rd_cfg_rdy  out  1  descriptor queue not full.
rd_bias  out  DW  bias of the active region.
rd_data  out  DW  kernel word.
rd_data_val  out  1  rd_data valid.
rd_data_last  out  1  final word of the final pass.
rd_data_rdy  in  1  downstream accepts.
rd_region_done  out  1  one-cycle pulse when a region retires.

Behaviour:
- Reset:
  - Outputs: rd_bias=0, rd_data=0, rd_data_val=0, rd_data_last=0, rd_region_done=0, rd_cfg_rdy=1.
  - Internal: wr_ptr=0, wr_ptr_wrap=0, wr_end=0, wr_end_wrap=1, so wr_data_rdy=0 until the first wr_cfg_set. Descriptor queue is emptied and the FSM returns to IDLE.
  - Memory contents are not cleared.
  - Reset mid-stream aborts the region immediately; no done pulse is generated.
- Write side:
  - wr_data_rdy = ~((wr_ptr_wrap != wr_end_wrap) && (wr_ptr == wr_end)).
  - On val&rdy: mem[wr_ptr] <= wr_data; wr_ptr increments. At MEM_DEPTH-1 it goes to 0 and toggles wr_ptr_wrap.
  - On wr_cfg_set: wr_end <= wr_cfg_end. If the old wr_end >= wr_cfg_end, toggle wr_end_wrap.
  - A write and wr_cfg_set in the same cycle are both applied.
- Descriptor queue:
  - Synchronous FIFO of {start, end, rpt}, depth 2^CFG_AWIDTH.
  - Push on rd_cfg_val&rd_cfg_rdy. rd_cfg_rdy = not full.
  - Push and pop in the same cycle are legal when the queue is non-empty.
  - Descriptors with start==end are illegal and must not be pushed.
- Read FSM states:
  - IDLE: if the queue is non-empty, pop it, load start/end/rpt, rd_ptr<=start, pass_cnt<=0, go to BIAS.
  - BIAS: rd_bias<=mem[rd_ptr]; rd_ptr<=start+1; go to FILL.
  - FILL: rd_data<=mem[rd_ptr]; rd_data_val<=1; rd_data_last<=(rd_ptr==end && pass_cnt==rpt_eff-1); advance rd_ptr; go to STREAM.
  - STREAM, on rd_data_val&rd_data_rdy:
    - If rd_data_last: rd_data_val<=0, rd_data_last<=0, rd_region_done<=1, go to IDLE. rd_data keeps its last value.
    - Otherwise: fetch the next word as in FILL.
- Pointer advance:
  - rd_ptr==end: rd_ptr goes to start+1 and pass_cnt increments. This takes precedence over the memory wrap.
  - rd_ptr==MEM_DEPTH-1: rd_ptr goes to 0.
- Latency and handshake:
  - Bias is valid 2 cycles after the pop. The first rd_data_val is 3 cycles after the pop. The next region's first word is 4 cycles after the last handshake.
  - rd_data, rd_data_val and rd_data_last hold stable while rd_data_val&~rd_data_rdy.
  - rd_bias changes only in the BIAS state, which is always while rd_data_val=0.
- Hazards: a same-address read and write in one cycle reads the old data. Overwrite protection of regions not yet read is the host's job, via wr_cfg_end.

Test Plan:
- Single region: after reset, wr_cfg_set end=6; write words A0..A5; push {start=0, end=5, rpt=1} -> rd_bias=A0; rd_data streams A1..A5; rd_data_last with A5; one rd_region_done pulse; rd_data_val=0 afterwards.
- Repeat: push {0, 3, 3} with rd_data_rdy=1 -> A1,A2,A3 three times (9 beats); last only on beat 9; bias loaded once.
- Queue chaining: push {0,2,1} and {3,5,2} back-to-back -> rd_cfg_rdy=0 while the queue is full; region 2 has bias=A3 and data A4,A5,A4,A5; two done pulses.
- Wrap and backpressure: MEM_AWIDTH=3; write 8 words; push {6, 1, 1}; toggle rd_data_rdy every other cycle -> data W7,W0,W1; rd_data stable while stalled.
- Write full: wr_cfg_end=4 -> wr_data_rdy=0 after 4 writes; then wr_cfg_end=2 -> wrap bit toggles, writes resume at addresses 4..7 and 0..1.
- Reset mid-stream: assert rst during beat 2 -> next cycle rd_data_val=0, rd_bias=0, queue empty, no done pulse.
